// File: rtl/hex_display_scanner.sv
// Time-multiplexes one hex-to-7-segment decoder across DIGITS segment registers.
// A load captures value/blank and writes one digit per clock. HEX can also blink from a free-running prescaler.

module hex_seg_lane (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_we,
  input  logic [6:0] i_pat,
  output logic [6:0] o_seg
);
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n)  o_seg <= 7'h7F;
    else if (i_we) o_seg <= i_pat;
endmodule

module hex_display_scanner #(
  parameter int DIGITS    = 8,
  parameter int BLINK_DIV = 25000000
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_load,
  input  logic [4*DIGITS-1:0]   i_value,
  input  logic [DIGITS-1:0]     i_blank,
  input  logic                  i_blink_en,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [7*DIGITS-1:0]   o_hex
);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PW = $clog2(BLINK_DIV);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t                  r_state, w_state_nxt;
  logic [IW-1:0]           r_idx;
  logic [DIGITS-1:0][3:0]  r_nib_sh;
  logic [DIGITS-1:0]       r_blank_sh;
  logic                    r_busy, r_done;
  logic [PW-1:0]           r_pre;
  logic                    r_phase;
  logic                    w_cap, w_wr, w_last;
  logic [6:0]              w_pat;
  logic [DIGITS-1:0][6:0]  w_seg;

  function automatic logic [6:0] f_dec(input logic [3:0] n);
    case (n)
      4'h0: f_dec = 7'b0000001;  4'h1: f_dec = 7'b1001111;
      4'h2: f_dec = 7'b0010010;  4'h3: f_dec = 7'b0000110;
      4'h4: f_dec = 7'b1001100;  4'h5: f_dec = 7'b0100100;
      4'h6: f_dec = 7'b0100000;  4'h7: f_dec = 7'b0001111;
      4'h8: f_dec = 7'b0000000;  4'h9: f_dec = 7'b0001100;
      4'hA: f_dec = 7'b0001000;  4'hB: f_dec = 7'b1100000;
      4'hC: f_dec = 7'b0110001;  4'hD: f_dec = 7'b1000010;
      4'hE: f_dec = 7'b0110000;  default: f_dec = 7'b0111000;
    endcase
  endfunction

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;

  always_comb begin
    w_state_nxt = r_state;
    w_cap       = 1'b0;
    w_wr        = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      IDLE: if (i_load) begin
        w_cap       = 1'b1;
        w_state_nxt = SCAN;
      end
      SCAN: begin
        w_wr = 1'b1;
        if (r_idx == IW'(DIGITS-1)) begin
          w_last      = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Shadow copies decouple the scan from live value/blank changes.
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_idx      <= '0;
      r_nib_sh   <= '0;
      r_blank_sh <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_cap) begin
        r_nib_sh   <= i_value;
        r_blank_sh <= i_blank;
        r_idx      <= '0;
        r_busy     <= 1'b1;
      end else if (w_wr) begin
        r_idx  <= w_last ? '0 : r_idx + IW'(1);
        r_busy <= ~w_last;
      end
    end

  assign w_pat = r_blank_sh[r_idx] ? 7'h7F : f_dec(r_nib_sh[r_idx]);

  for (genvar k = 0; k < DIGITS; k++) begin : g_lane
    hex_seg_lane u_lane (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_we    (w_wr && (r_idx == IW'(k))),
      .i_pat   (w_pat),
      .o_seg   (w_seg[k])
    );
  end

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_pre   <= '0;
      r_phase <= 1'b0;
    end else if (r_pre == PW'(BLINK_DIV-1)) begin
      r_pre   <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_pre   <= r_pre + PW'(1);
    end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_hex  = w_seg | {7*DIGITS{i_blink_en & r_phase}};
endmodule

// File: tb/tb_hex_display_scanner.sv
// Scoreboard bench: stimulus pushes expected HEX per scan, a monitor checks it on each done pulse.
module tb_hex_display_scanner;
  localparam int D  = 8;
  localparam int BD = 4;
  localparam int HW = 7*D;

  localparam logic [6:0] G0 = 7'b0000001, G1 = 7'b1001111, G2 = 7'b0010010, G3 = 7'b0000110;
  localparam logic [6:0] G4 = 7'b1001100, G5 = 7'b0100100, G6 = 7'b0100000, G7 = 7'b0001111;
  localparam logic [6:0] G8 = 7'b0000000, G9 = 7'b0001100, GA = 7'b0001000, GB = 7'b1100000;
  localparam logic [6:0] GC = 7'b0110001, GD = 7'b1000010, GE = 7'b0110000, GF = 7'b0111000;
  localparam logic [6:0] OF = 7'b1111111;

  logic          clk = 1'b0, rst_n = 1'b0, load = 1'b0, blink_en = 1'b0;
  logic [4*D-1:0] value = '0;
  logic [D-1:0]  blank = '0;
  logic          busy, done;
  logic [HW-1:0] hex;

  logic [HW-1:0] q[$];
  logic [HW-1:0] shown;
  int n_cmp = 0, n_err = 0, ncyc = 0;

  hex_display_scanner #(.DIGITS(D), .BLINK_DIV(BD)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_load(load), .i_value(value), .i_blank(blank),
    .i_blink_en(blink_en), .o_busy(busy), .o_done(done), .o_hex(hex)
  );

  always #5 clk = ~clk;

  // cycles since reset release; drives the expected blink phase
  always @(posedge clk or negedge rst_n)
    if (!rst_n) ncyc <= 0;
    else        ncyc <= ncyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h @%0t", name, act, exp, $time);
    end
  endtask

  // monitor: every done pulse must match the oldest outstanding scan
  always @(negedge clk)
    if (rst_n && done) begin
      if (q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_done: got done=1 expected no pulse @%0t", $time);
      end else begin
        chk("scan_hex", 64'(hex), 64'(q.pop_front()));
      end
    end

  task automatic do_scan(input logic [31:0] v, input logic [7:0] b, input logic [HW-1:0] ex,
                         input int mid, input bit chain, input logic [31:0] vc,
                         input logic [7:0] bc, input logic [HW-1:0] exc);
    logic [HW-1:0] p;
    int cnt;
    @(negedge clk); load = 1'b1; value = v; blank = b; q.push_back(ex);
    for (int j = 0; j <= D; j++) begin
      @(negedge clk);
      if (j == 0) begin load = 1'b0; value = ~v; blank = ~b; end
      if (mid >= 0 && j == mid)     begin load = 1'b1; value = '0; blank = '0; end
      if (mid >= 0 && j == mid + 1) load = 1'b0;
      if (chain && j == D - 1) begin load = 1'b1; value = vc; blank = bc; q.push_back(exc); end
      for (int k = 0; k < D; k++) p[7*k +: 7] = (k < j) ? ex[7*k +: 7] : shown[7*k +: 7];
      chk("digit_walk", 64'(hex), 64'(p));
      chk("busy_done", {62'd0, busy, done}, {62'd0, (j < D), (j == D)});
    end
    shown = ex;
    @(negedge clk);
    chk("after_done", {62'd0, busy, done}, chain ? 64'd2 : 64'd0);
    if (chain) begin
      load = 1'b0;
      cnt = 0;
      while (!done && cnt < 20) begin @(negedge clk); cnt++; end
      chk("chain_latency", 64'(cnt), 64'(D));
      shown = exc;
      @(negedge clk);
    end
  endtask

  initial begin
    shown = '1;
    repeat (3) @(negedge clk);
    chk("reset_hex", 64'(hex), 64'(shown));
    chk("reset_busy_done", {62'd0, busy, done}, 64'd0);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("idle_hex", 64'(hex), 64'(shown));
    chk("idle_busy_done", {62'd0, busy, done}, 64'd0);

    do_scan(32'h0123ABCD, 8'h00, {G0,G1,G2,G3,GA,GB,GC,GD}, -1, 0, '0, '0, '0);
    do_scan(32'h89ABCDEF, 8'h0F, {G8,G9,GA,GB,OF,OF,OF,OF}, -1, 0, '0, '0, '0);
    // mid-scan load ignored; load held into the done cycle starts the next scan
    do_scan(32'h456789EF, 8'h00, {G4,G5,G6,G7,G8,G9,GE,GF}, 3, 1,
            32'hFEDC0000, 8'hF0, {OF,OF,OF,OF,G0,G0,G0,G0});

    blink_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("blink_on", 64'(hex), ((ncyc / BD) % 2 == 1) ? 64'(HW'('1)) : 64'(shown));
    end
    blink_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("blink_off", 64'(hex), 64'(shown));
    end

    // asynchronous reset in the middle of a scan
    @(negedge clk); load = 1'b1; value = 32'h13579BDF; blank = '0;
    for (int j = 0; j <= 3; j++) begin @(negedge clk); if (j == 0) load = 1'b0; end
    #2 rst_n = 1'b0;
    #1;
    chk("abort_hex", 64'(hex), 64'(HW'('1)));
    chk("abort_busy_done", {62'd0, busy, done}, 64'd0);
    shown = '1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("abort_quiet", {62'd0, busy, done}, 64'd0);

    do_scan(32'h12345678, 8'h81, {OF,G2,G3,G4,G5,G6,G7,OF}, -1, 0, '0, '0, '0);
    repeat (4) @(negedge clk);
    chk("queue_drained", 64'(q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete within bound");
    $fatal(1, "timeout");
  end
endmodule
